// File: rtl/interval_fifo_arbiter_if.sv
// FIFO write-side handshake shared by the arbiter (master) and the FIFO (slave).
interface interval_fifo_arbiter_if #(
    parameter int CHW = 2,
    parameter int DW  = 32
);
    logic               fifo_w_en;
    logic               fifo_w_ready;
    logic [CHW+DW-1:0]  fifo_wdata;

    modport master (
        output fifo_w_en,
        output fifo_wdata,
        input  fifo_w_ready
    );

    modport slave (
        input  fifo_w_en,
        input  fifo_wdata,
        output fifo_w_ready
    );
endinterface

// File: rtl/interval_fifo_arbiter.sv
// Round-robin arbiter merging NCH interval strobes into one tagged FIFO write stream.
// Latency: strobe captured at edge k, fifo_w_en asserted after edge k+1 when the output register is free.
// Backpressure: output register holds while fifo_w_ready=0; one slot per channel absorbs, further strobes are counted as overruns.
module interval_fifo_arbiter #(
    parameter int NCH = 4,
    parameter int CHW = 2,
    parameter int DW  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          ch_stb,
    input  logic [NCH*DW-1:0]       ch_data,
    interval_fifo_arbiter_if.master fifo_if,
    input  logic                    clr_err,
    output logic [NCH-1:0]          overrun,
    output logic [NCH*8-1:0]        drop_cnt
);

    logic [NCH-1:0]           slot_vld_q, slot_vld_d;
    logic [NCH-1:0][DW-1:0]   slot_dat_q, slot_dat_d;
    logic [CHW-1:0]           last_q, last_d;
    logic                     w_en_q, w_en_d;
    logic [CHW+DW-1:0]        wdata_q, wdata_d;
    logic [NCH-1:0]           overrun_q, overrun_d;
    logic [NCH-1:0][7:0]      drop_cnt_q, drop_cnt_d;

    logic                     load_ok;
    logic                     gnt_vld;
    logic                     take;
    logic [CHW-1:0]           gnt_idx;
    logic [DW-1:0]            gnt_dat;
    logic [NCH-1:0]           gnt_oh;
    int                       sel_c;

    // Output register is free when empty or when its word leaves this edge.
    assign load_ok = !w_en_q || fifo_if.fifo_w_ready;
    assign take    = load_ok && gnt_vld;

    // Search starts one past the last granted channel, wrapping modulo NCH.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_dat = '0;
        sel_c   = 0;
        for (int i = 1; i <= NCH; i++) begin
            sel_c = (int'(last_q) + i) % NCH;
            if (!gnt_vld && slot_vld_q[sel_c]) begin
                gnt_vld = 1'b1;
                gnt_idx = CHW'(sel_c);
                gnt_dat = slot_dat_q[sel_c];
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (take) begin
            gnt_oh = NCH'(1) << gnt_idx;
        end
    end

    // A slot being granted out this edge may reload from a coincident strobe.
    always_comb begin
        slot_vld_d = slot_vld_q;
        slot_dat_d = slot_dat_q;
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_oh[k]) begin
                slot_vld_d[k] = 1'b0;
            end
            if (ch_stb[k]) begin
                if (!slot_vld_q[k] || gnt_oh[k]) begin
                    slot_vld_d[k] = 1'b1;
                    slot_dat_d[k] = ch_data[k*DW +: DW];
                end else begin
                    overrun_d[k] = 1'b1;
                    if (drop_cnt_q[k] != 8'hFF) begin
                        drop_cnt_d[k] = drop_cnt_q[k] + 8'd1;
                    end
                end
            end
        end
        if (clr_err) begin
            overrun_d  = '0;
            drop_cnt_d = '0;
        end
    end

    always_comb begin
        w_en_d  = w_en_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        if (load_ok) begin
            w_en_d = gnt_vld;
            if (gnt_vld) begin
                wdata_d = {gnt_idx, gnt_dat};
                last_d  = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_vld_q <= '0;
            slot_dat_q <= '0;
            last_q     <= CHW'(NCH - 1);
            w_en_q     <= 1'b0;
            wdata_q    <= '0;
            overrun_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            slot_dat_q <= slot_dat_d;
            last_q     <= last_d;
            w_en_q     <= w_en_d;
            wdata_q    <= wdata_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign fifo_if.fifo_w_en  = w_en_q;
    assign fifo_if.fifo_wdata = wdata_q;
    assign overrun            = overrun_q;
    assign drop_cnt           = drop_cnt_q;

endmodule

// File: tb/tb_interval_fifo_arbiter.sv
// Directed bench for interval_fifo_arbiter with a queue-based write scoreboard.
module tb_interval_fifo_arbiter;

    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int DW  = 32;

    logic                clk;
    logic                rst;
    logic [NCH-1:0]      ch_stb;
    logic [NCH*DW-1:0]   ch_data;
    logic                clr_err;
    logic [NCH-1:0]      overrun;
    logic [NCH*8-1:0]    drop_cnt;

    logic [CHW+DW-1:0]   exp_q[$];
    logic [CHW+DW-1:0]   exp_w;
    int                  checks;
    int                  errors;

    interval_fifo_arbiter_if #(.CHW(CHW), .DW(DW)) fifo_if ();

    interval_fifo_arbiter #(.NCH(NCH), .CHW(CHW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_stb   (ch_stb),
        .ch_data  (ch_data),
        .fifo_if  (fifo_if.master),
        .clr_err  (clr_err),
        .overrun  (overrun),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int c, input logic [DW-1:0] v);
        ch_data[c*DW +: DW] = v;
    endtask

    task automatic pulse(input logic [NCH-1:0] m);
        ch_stb = m;
        tick();
        ch_stb = '0;
    endtask

    task automatic expect_wr(input int c, input logic [DW-1:0] v);
        exp_q.push_back({CHW'(c), v});
    endtask

    // Monitor: every completed write is matched against the head of the queue.
    always @(negedge clk) begin
        if (rst && fifo_if.fifo_w_en && fifo_if.fifo_w_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got %0h required no write", fifo_if.fifo_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if (fifo_if.fifo_wdata !== exp_w) begin
                    errors++;
                    $display("FAIL write_data: got %0h required %0h", fifo_if.fifo_wdata, exp_w);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        ch_stb  = '0;
        ch_data = '0;
        clr_err = 1'b0;
        fifo_if.fifo_w_ready = 1'b1;

        // Reset held with strobes active
        #2 rst = 1'b0;
        ch_stb = 4'hF;
        for (int c = 0; c < NCH; c++) set_data(c, 32'hAA00 + c);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_w_en", 64'(fifo_if.fifo_w_en), 64'd0);
        check("rst_wdata", 64'(fifo_if.fifo_wdata), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        tick();
        rst = 1'b1;
        ch_stb = '0;
        tick();

        // First write latency: strobe ch2
        set_data(2, 32'h1F4);
        expect_wr(2, 32'h1F4);
        pulse(4'b0100);
        @(negedge clk);
        check("lat_after_k", 64'(fifo_if.fifo_w_en), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_after_k1_en", 64'(fifo_if.fifo_w_en), 64'd1);
        check("lat_after_k1_data", 64'(fifo_if.fifo_wdata), {30'd0, 2'd2, 32'h1F4});
        tick();
        @(negedge clk);
        check("lat_after_k2_en", 64'(fifo_if.fifo_w_en), 64'd0);

        // Fresh reset so channel 0 has priority again
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Simultaneous strobes on all channels
        set_data(0, 32'd10);
        set_data(1, 32'd20);
        set_data(2, 32'd30);
        set_data(3, 32'd40);
        expect_wr(0, 32'd10);
        expect_wr(1, 32'd20);
        expect_wr(2, 32'd30);
        expect_wr(3, 32'd40);
        pulse(4'b1111);
        repeat (5) tick();
        @(negedge clk);
        check("all4_idle", 64'(fifo_if.fifo_w_en), 64'd0);
        check("all4_drained", 64'(exp_q.size()), 64'd0);
        check("all4_no_overrun", 64'(overrun), 64'd0);
        tick();

        // Round-robin: ch1 held in output, ch0 and ch3 pending
        fifo_if.fifo_w_ready = 1'b0;
        set_data(1, 32'h11);
        expect_wr(1, 32'h11);
        pulse(4'b0010);
        tick();
        set_data(0, 32'hA0);
        set_data(3, 32'hA3);
        expect_wr(3, 32'hA3);
        expect_wr(0, 32'hA0);
        pulse(4'b1001);
        @(negedge clk);
        check("rr_hold_ch1", 64'(fifo_if.fifo_wdata), {30'd0, 2'd1, 32'h11});
        tick();
        fifo_if.fifo_w_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("rr_drained", 64'(exp_q.size()), 64'd0);
        tick();

        // Backpressure and overrun on ch0
        fifo_if.fifo_w_ready = 1'b0;
        set_data(0, 32'd5);
        pulse(4'b0001);
        tick();
        set_data(0, 32'd6);
        pulse(4'b0001);
        tick();
        set_data(0, 32'd7);
        pulse(4'b0001);
        @(negedge clk);
        check("bp_hold_en", 64'(fifo_if.fifo_w_en), 64'd1);
        check("bp_hold_data", 64'(fifo_if.fifo_wdata), {30'd0, 2'd0, 32'd5});
        check("bp_drop_cnt0", 64'(drop_cnt[7:0]), 64'd1);
        check("bp_overrun", 64'(overrun), 64'b0001);
        expect_wr(0, 32'd5);
        expect_wr(0, 32'd6);
        tick();
        fifo_if.fifo_w_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        tick();

        // Saturation and clear on ch1
        fifo_if.fifo_w_ready = 1'b0;
        set_data(1, 32'h100);
        pulse(4'b0010);
        tick();
        set_data(1, 32'h101);
        pulse(4'b0010);
        ch_stb = 4'b0010;
        for (int i = 0; i < 300; i++) begin
            set_data(1, 32'h200 + i);
            tick();
        end
        ch_stb = '0;
        @(negedge clk);
        check("sat_drop_cnt1", 64'(drop_cnt[15:8]), 64'd255);
        check("sat_overrun", 64'(overrun), 64'b0011);
        tick();
        clr_err = 1'b1;
        ch_stb  = 4'b0010;
        tick();
        clr_err = 1'b0;
        ch_stb  = '0;
        @(negedge clk);
        check("clr_drop_cnt", 64'(drop_cnt), 64'd0);
        check("clr_overrun", 64'(overrun), 64'd0);
        check("clr_keeps_out", 64'(fifo_if.fifo_wdata), {30'd0, 2'd1, 32'h100});
        expect_wr(1, 32'h100);
        expect_wr(1, 32'h101);
        tick();
        fifo_if.fifo_w_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("clr_drained", 64'(exp_q.size()), 64'd0);
        tick();

        // Same-edge regrant on ch3
        set_data(3, 32'h333);
        expect_wr(3, 32'h333);
        expect_wr(3, 32'h444);
        ch_stb = 4'b1000;
        tick();
        set_data(3, 32'h444);
        tick();
        ch_stb = '0;
        repeat (4) tick();
        @(negedge clk);
        check("regrant_overrun", 64'(overrun), 64'd0);
        check("regrant_drop_cnt3", 64'(drop_cnt[31:24]), 64'd0);
        check("regrant_idle", 64'(fifo_if.fifo_w_en), 64'd0);

        repeat (2) tick();
        @(negedge clk);
        check("final_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interval_fifo_arbiter.md
Name: interval_fifo_arbiter

Overview:
- Shares one FIFO write port among NCH pulse-interval detector channels (one per photodiode sensor).
- Each channel emits single-cycle, non-stallable interval strobes. The arbiter buffers one pending word per channel and grants the FIFO write port round-robin.
- Written words are tagged with the channel index. Overruns are counted per channel.
- Sits between the detector bank and the FIFO write side; the FIFO reader sees a tagged interval stream.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- CHW, 2, channel tag width; must satisfy 2^CHW >= NCH.
- DW, 32, interval data width per channel.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- ch_stb  in  NCH  per-channel one-cycle strobe: new interval valid.
- ch_data  in  NCH*DW  per-channel interval; channel c occupies bits [c*DW +: DW].
- fifo_w_en  out  1  write request to FIFO, registered.
- fifo_w_ready  in  1  FIFO can accept a write this cycle.
- fifo_wdata  out  CHW+DW  {channel tag, interval}, registered.
- clr_err  in  1  synchronous clear of drop counters and overrun flags.
- overrun  out  NCH  sticky per-channel overrun flag.
- drop_cnt  out  NCH*8  per-channel saturating drop counter.

Behaviour:
- Reset (rst=0, asynchronous) clears every output and all internal state:
  - fifo_w_en=0, fifo_wdata=0, overrun=0, drop_cnt=0.
  - All pending slots empty; round-robin pointer last=NCH-1, so channel 0 has priority first.
- Transfer rule: a write completes on a rising edge where fifo_w_en=1 and fifo_w_ready=1.
  - fifo_w_en and fifo_wdata stay constant until the write completes.
- Pending slot per channel (valid bit + DW data):
  - Capture: at an edge with ch_stb[c]=1 and slot c empty (or being granted this edge, see below), slot c loads ch_data[c] and is marked valid.
  - Overrun: at an edge with ch_stb[c]=1 while slot c is valid and not granted this edge:
    - slot keeps its old data;
    - overrun[c] is set;
    - drop_cnt[c] increments, saturating at 255.
- Output register states:
  - EMPTY (fifo_w_en=0).
  - FULL (fifo_w_en=1).
  - The output register may load when it is EMPTY or when its write completes this edge.
- Grant selection: if the output register may load and any slot is valid, grant the first valid channel searching last+1, last+2, … modulo NCH. On grant:
  - fifo_wdata <= {c, slot_c data}; fifo_w_en <= 1;
  - slot c is cleared; last <= c.
  - If no slot is valid, fifo_w_en <= 0.
- Simultaneous strobe and grant on the same channel: slot c is granted out and loaded with the new ch_data[c] in the same edge. This is not an overrun.
- Latency: strobe at edge k → slot valid after k → fifo_w_en=1 after edge k+1 at the earliest (when the output register was free).
- Throughput: one write per cycle while fifo_w_ready stays 1.
- fifo_w_ready=0: the output register holds; slots continue capturing; overruns may occur.
- No strobe is ever lost except through an overrun, and every overrun is counted.
- clr_err=1 at an edge clears overrun and drop_cnt. It takes priority over an increment in the same edge. Slots and the output register are unaffected.
- Reset mid-operation: pending and in-flight words are discarded; nothing is written after rst asserts.

Test Plan:
- Reset check: drive rst=0 with strobes active → fifo_w_en=0, overrun=0, drop_cnt=0. Release rst, strobe ch2 data=0x1F4 → one write with wdata={2'd2,32'h1F4}, exactly two edges after the strobe edge.
- Simultaneous strobes: ch_stb=4'b1111, data 10,20,30,40, fifo_w_ready=1 → four consecutive writes in order ch0,ch1,ch2,ch3; then fifo_w_en=0.
- Round-robin fairness: after a ch1 grant, ch0 and ch3 pending → ch3 written before ch0.
- Backpressure and overrun: fifo_w_ready=0, strobe ch0 three times (5,6,7) → the output register holds 5, the slot holds 6, drop_cnt[0]=1, overrun[0]=1. Set ready=1 → writes 5 then 6; 7 is never written.
- Saturation and clear: 300 overruns on ch1 → drop_cnt[1]=255. Pulse clr_err → 0 and overrun[1]=0, while a pending word is still written.
- Same-edge regrant: ch3 slot granted on the same edge as a new ch3 strobe → no overrun; both words are written in order.
